// File: rtl/ree_boot_ahb_master_if.sv
// AHB-Lite master port bundle linking the REE boot sequencer to the bus matrix.
interface ree_boot_ahb_master_if;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic [31:0] hwdata;
   logic        hready;
   logic [1:0]  hresp;

   modport master (
      output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
      input  hready, hresp
   );

   modport slave (
      input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
      output hready, hresp
   );
endinterface

// File: rtl/ree_boot_ahb_master.sv
// AHB-Lite write sequencer: holds REE in reset, programs its boot vector, optionally releases it.
// Optional build macro REE_BOOT_ERR_RETRY_EN: retry the whole sequence once after the first ERROR.
module ree_boot_ahb_master #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter logic [31:0] ADDR_OFS  = 32'h4,
   parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
   input  logic        hclk,
   input  logic        hrst_b,
   // Request handshake: a request is taken at a rising hclk edge where req_valid
   // and req_ready are both high; req_boot_addr/req_hold are captured at that edge.
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_boot_addr,
   input  logic        req_hold,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_step,
   output logic [2:0]  dbg_state,
   ree_boot_ahb_master_if.master ahb
);

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] RESP_ERROR   = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE, S_A_CTRL0, S_A_ADDR, S_A_CTRL1, S_D_LAST, S_ERR_WAIT
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] haddr_q, haddr_d;
   logic [1:0]  htrans_q, htrans_d;
   logic        hwrite_q, hwrite_d;
   logic [31:0] hwdata_q, hwdata_d;
   logic [31:0] boot_addr_q, boot_addr_d;
   logic        hold_q, hold_d;
   logic [1:0]  err_step_q, err_step_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [1:0]  data_step;
   logic        data_err;
`ifdef REE_BOOT_ERR_RETRY_EN
   logic        retried_q, retried_d;
`endif

   // Step whose data phase is on the bus in the current state (0 = none).
   assign data_step = (state_q == S_A_ADDR)  ? 2'd1 :
                      (state_q == S_A_CTRL1) ? 2'd2 :
                      (state_q == S_D_LAST)  ? (hold_q ? 2'd2 : 2'd3) : 2'd0;
   assign data_err  = (ahb.hresp == RESP_ERROR) && !ahb.hready;

   always_ff @(posedge hclk or negedge hrst_b) begin
      if (!hrst_b) begin
         state_q     <= S_IDLE;
         haddr_q     <= '0;
         htrans_q    <= TRANS_IDLE;
         hwrite_q    <= 1'b0;
         hwdata_q    <= '0;
         boot_addr_q <= '0;
         hold_q      <= 1'b0;
         err_step_q  <= 2'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef REE_BOOT_ERR_RETRY_EN
         retried_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         haddr_q     <= haddr_d;
         htrans_q    <= htrans_d;
         hwrite_q    <= hwrite_d;
         hwdata_q    <= hwdata_d;
         boot_addr_q <= boot_addr_d;
         hold_q      <= hold_d;
         err_step_q  <= err_step_d;
         done_q      <= done_d;
         err_q       <= err_d;
`ifdef REE_BOOT_ERR_RETRY_EN
         retried_q   <= retried_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      haddr_d     = haddr_q;
      htrans_d    = htrans_q;
      hwdata_d    = hwdata_q;
      boot_addr_d = boot_addr_q;
      hold_d      = hold_q;
      err_step_d  = err_step_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
`ifdef REE_BOOT_ERR_RETRY_EN
      retried_d   = retried_q;
`endif
      // First ERROR cycle cancels any pending address phase.
      if (data_step != 2'd0 && data_err) begin
         state_d    = S_ERR_WAIT;
         htrans_d   = TRANS_IDLE;
         err_step_d = data_step;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  state_d     = S_A_CTRL0;
                  boot_addr_d = req_boot_addr;
                  hold_d      = req_hold;
                  err_step_d  = 2'd0;
                  haddr_d     = BASE_ADDR;
                  htrans_d    = TRANS_NONSEQ;
`ifdef REE_BOOT_ERR_RETRY_EN
                  retried_d   = 1'b0;
`endif
               end
            end
            S_A_CTRL0: begin
               if (ahb.hready) begin
                  hwdata_d = 32'd0;
                  haddr_d  = BASE_ADDR + ADDR_OFS;
                  state_d  = S_A_ADDR;
               end
            end
            S_A_ADDR: begin
               if (ahb.hready) begin
                  hwdata_d = boot_addr_q;
                  if (hold_q) begin
                     htrans_d = TRANS_IDLE;
                     state_d  = S_D_LAST;
                  end else begin
                     haddr_d  = BASE_ADDR;
                     state_d  = S_A_CTRL1;
                  end
               end
            end
            S_A_CTRL1: begin
               if (ahb.hready) begin
                  hwdata_d = 32'd1;
                  htrans_d = TRANS_IDLE;
                  state_d  = S_D_LAST;
               end
            end
            S_D_LAST: begin
               if (ahb.hready) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
            S_ERR_WAIT: begin
               if (ahb.hready) begin
`ifdef REE_BOOT_ERR_RETRY_EN
                  if (!retried_q) begin
                     retried_d = 1'b1;
                     state_d   = S_A_CTRL0;
                     haddr_d   = BASE_ADDR;
                     htrans_d  = TRANS_NONSEQ;
                  end else begin
                     state_d = S_IDLE;
                     err_d   = 1'b1;
                  end
`else
                  state_d = S_IDLE;
                  err_d   = 1'b1;
`endif
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      hwrite_d = (htrans_d == TRANS_NONSEQ);
   end

   assign req_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign err        = err_q;
   assign err_step   = err_step_q;
   assign dbg_state  = state_q;

   assign ahb.haddr  = haddr_q;
   assign ahb.htrans = htrans_q;
   assign ahb.hwrite = hwrite_q;
   assign ahb.hwdata = hwdata_q;
   assign ahb.hsize  = 3'b010;
   assign ahb.hburst = 3'b000;
   assign ahb.hprot  = HPROT_VAL;

endmodule

// File: tb/tb_ree_boot_ahb_master.sv
// Randomized bench for ree_boot_ahb_master: a behavioural AHB slave with wait/error injection
// and a sequence-level model of expected writes, pulse timing and final slave registers.
module tb_ree_boot_ahb_master;

   localparam logic [31:0] CTRL_A = 32'h3000_0000;
   localparam logic [31:0] BOOT_A = 32'h3000_0004;
`ifdef REE_BOOT_ERR_RETRY_EN
   localparam int RETRIES = 1;
`else
   localparam int RETRIES = 0;
`endif

   logic        hclk;
   logic        hrst_b;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_boot_addr;
   logic        req_hold;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_step;
   logic [2:0]  dbg_state;

   ree_boot_ahb_master_if bus ();

   ree_boot_ahb_master dut (
      .hclk          (hclk),
      .hrst_b        (hrst_b),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_boot_addr (req_boot_addr),
      .req_hold      (req_hold),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .err_step      (err_step),
      .dbg_state     (dbg_state),
      .ahb           (bus)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   // Write expected for a given step of the boot sequence.
   function automatic logic [63:0] write_of(input int ord, input logic [31:0] a);
      case (ord)
         1:       return {CTRL_A, 32'h0000_0000};
         2:       return {BOOT_A, a};
         default: return {CTRL_A, 32'h0000_0001};
      endcase
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, "_htrans"},    64'(bus.htrans), 64'(0));
      check({tag, "_haddr"},     64'(bus.haddr), 64'(0));
      check({tag, "_hwdata"},    64'(bus.hwdata), 64'(0));
      check({tag, "_hwrite"},    64'(bus.hwrite), 64'(0));
      check({tag, "_busy"},      64'(busy), 64'(0));
      check({tag, "_req_ready"}, 64'(req_ready), 64'(1));
      check({tag, "_done"},      64'(done), 64'(0));
      check({tag, "_err"},       64'(err), 64'(0));
      check({tag, "_err_step"},  64'(err_step), 64'(0));
   endtask

   // One full request; called and returning at a sample point (1 time unit after posedge).
   task automatic run_seq(input logic [31:0] addr, input logic hold, input int wait_ord,
                          input int wait_n, input int err_ord, input int err_att, input int rst_rel);
      int steps, n_err_att, n_att, last, exp_done_rel;
      bit exp_err;
      logic [63:0] exp_q[$];
      logic [63:0] got_q[$];
      logic [31:0] slv_ctrl, slv_addr, exp_ctrl, exp_addr, dp_addr;
      logic [63:0] prev_ad;
      logic [1:0]  prev_tr;
      int rel, attempt, dp_ord, waits_left, done_cnt, err_cnt, done_rel, err_rel, err1_rel;
      int busy_bad, bad_trans, fin_post;
      bit dp_valid, err1_seen, finished, prev_wait, prev_err1;

      steps     = hold ? 2 : 3;
      n_err_att = (err_ord >= 1 && err_ord <= steps) ? err_att : 0;
      exp_err   = n_err_att > RETRIES;
      n_att     = exp_err ? RETRIES + 1 : n_err_att + 1;
      for (int a = 1; a <= n_att; a++) begin
         last = (a <= n_err_att) ? err_ord - 1 : steps;
         for (int o = 1; o <= last; o++) exp_q.push_back(write_of(o, addr));
      end
      exp_ctrl = 32'h1;
      exp_addr = 32'h0;
      foreach (exp_q[i]) begin
         if (exp_q[i][63:32] == CTRL_A) exp_ctrl = exp_q[i][31:0];
         else exp_addr = exp_q[i][31:0];
      end
      exp_done_rel = (hold ? 4 : 5) + ((wait_ord >= 1 && wait_ord <= steps) ? wait_n : 0);

      slv_ctrl = 32'h1; slv_addr = 32'h0; dp_addr = '0; prev_ad = '0; prev_tr = '0;
      attempt = 1; dp_ord = 0; waits_left = 0; done_cnt = 0; err_cnt = 0;
      done_rel = 0; err_rel = 0; err1_rel = 0; busy_bad = 0; bad_trans = 0; fin_post = 0;
      dp_valid = 0; err1_seen = 0; finished = 0; prev_wait = 0; prev_err1 = 0;

      check("idle_ready", 64'(req_ready), 64'(1));
      req_boot_addr = addr;
      req_hold      = hold;
      req_valid     = 1'b1;
      tick();
      rel = 1;

      for (int k = 0; k < 300 && fin_post < 3; k++) begin
         if (rel == rst_rel) begin
            req_valid = 1'b0;
            hrst_b    = 1'b0;
            #1;
            check_reset_values("mid_reset");
            bus.hready = 1'b1;
            bus.hresp  = 2'b00;
            @(negedge hclk);
            hrst_b = 1'b1;
            tick();
            return;
         end
         if (bus.htrans != 2'b00 && bus.htrans != 2'b10) bad_trans++;
         if (bus.hwrite !== (bus.htrans == 2'b10)) bad_trans++;
         if (prev_err1) check("htrans_after_err", 64'(bus.htrans), 64'(0));
         if (prev_wait) begin
            check("wait_addr_data", {bus.haddr, bus.hwdata}, prev_ad);
            check("wait_trans", 64'(bus.htrans), 64'(prev_tr));
         end
         if (done) begin done_cnt++; if (done_rel == 0) done_rel = rel; end
         if (err) begin err_cnt++; if (err_rel == 0) err_rel = rel; end
         if ((done || err) && !finished) finished = 1;
         if (busy !== !finished) busy_bad++;
         if (req_ready !== !busy) busy_bad++;
         if (finished) fin_post++;

         // Unrelated requests while busy must be ignored.
         if (req_ready) req_valid = 1'b0;
         else begin
            req_valid     = 1'($urandom_range(0, 1));
            req_boot_addr = $urandom;
            req_hold      = 1'($urandom_range(0, 1));
         end

         prev_err1 = 0;
         prev_wait = 0;
         if (dp_valid && !err1_seen && dp_ord == err_ord && attempt <= err_att) begin
            bus.hready = 1'b0; bus.hresp = 2'b01;
            err1_seen = 1; prev_err1 = 1; err1_rel = rel;
         end else if (dp_valid && err1_seen) begin
            bus.hready = 1'b1; bus.hresp = 2'b01;
         end else if (dp_valid && dp_ord == wait_ord && waits_left > 0) begin
            bus.hready = 1'b0; bus.hresp = 2'b00;
            waits_left--; prev_wait = 1;
            prev_ad = {bus.haddr, bus.hwdata};
            prev_tr = bus.htrans;
         end else begin
            bus.hready = 1'b1; bus.hresp = 2'b00;
         end

         if (bus.hready) begin
            if (dp_valid) begin
               if (bus.hresp == 2'b00) begin
                  got_q.push_back({dp_addr, bus.hwdata});
                  if (dp_addr == CTRL_A) slv_ctrl = bus.hwdata;
                  else if (dp_addr == BOOT_A) slv_addr = bus.hwdata;
               end else begin
                  attempt++;
                  dp_ord = 0;
               end
               dp_valid = 0;
            end
            if (bus.htrans == 2'b10) begin
               dp_valid = 1; dp_addr = bus.haddr; dp_ord++;
               waits_left = wait_n; err1_seen = 0;
            end
         end
         tick();
         rel++;
      end
      bus.hready = 1'b1;
      bus.hresp  = 2'b00;

      check("seq_completes", 64'(finished), 64'(1));
      check("done_pulses", 64'(done_cnt), 64'(exp_err ? 0 : 1));
      check("err_pulses", 64'(err_cnt), 64'(exp_err ? 1 : 0));
      if (n_err_att == 0) check("done_latency", 64'(done_rel), 64'(exp_done_rel));
      if (exp_err) begin
         check("err_step", 64'(err_step), 64'(err_ord));
         check("err_latency", 64'(err_rel), 64'(err1_rel + 2));
      end
      check("busy_ready", 64'(busy_bad), 64'(0));
      check("trans_legal", 64'(bad_trans), 64'(0));
      check("write_count", 64'(got_q.size()), 64'(exp_q.size()));
      foreach (exp_q[i]) if (i < got_q.size()) check("write", got_q[i], exp_q[i]);
      check("slave_ctrl", 64'(slv_ctrl), 64'(exp_ctrl));
      check("slave_addr", 64'(slv_addr), 64'(exp_addr));
   endtask

   initial begin
      hrst_b        = 1'b0;
      req_valid     = 1'b0;
      req_boot_addr = '0;
      req_hold      = 1'b0;
      bus.hready    = 1'b1;
      bus.hresp     = 2'b00;
      repeat (3) @(posedge hclk);
      #1;
      check_reset_values("reset");
      check("hsize", 64'(bus.hsize), 64'(3'b010));
      check("hburst", 64'(bus.hburst), 64'(3'b000));
      check("hprot", 64'(bus.hprot), 64'(4'b0011));
      @(negedge hclk);
      hrst_b = 1'b1;
      tick();

      // Directed cases: addr, hold, wait_ord, wait_n, err_ord, err_att, rst_rel
      run_seq(32'h8000_0100, 1'b0, 0, 0, 0, 0, 0);
      run_seq(32'h1234_5678, 1'b1, 0, 0, 0, 0, 0);
      run_seq($urandom, 1'b0, 2, 3, 0, 0, 0);
      run_seq($urandom, 1'b0, 0, 0, 3, 1, 0);
      run_seq($urandom, 1'b0, 0, 0, 3, 2, 0);
      run_seq($urandom, 1'b0, 0, 0, 0, 0, 2);
      run_seq($urandom, 1'b0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 12; i++) begin
         run_seq($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 4),
                 ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                 $urandom_range(1, 2), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
